// File: rtl/rsc_viterbi_decoder_if.sv
// Handshake and result bundle for the hard-decision RSC Viterbi decoder.
// The master side (source/bench) drives the pair stream. The slave side
// (decoder) returns status and the decoded block.
interface rsc_viterbi_decoder_if #(
    parameter int K    = 40,
    parameter int PM_W = 8
);
    logic            in_valid;
    logic            sys_in;
    logic            par_in;
    logic            busy;
    logic [0:K-1]    dout;
    logic            done;
    logic [PM_W-1:0] err_count;

    modport master (
        output in_valid, sys_in, par_in,
        input  busy, dout, done, err_count
    );

    modport slave (
        input  in_valid, sys_in, par_in,
        output busy, dout, done, err_count
    );
endinterface

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 8-state NB-IoT turbo constituent
// RSC code (feedback 13, parity 15). It takes K info pairs and then 3 tail
// pairs, and runs one ACS step per accepted pair. It then traces back from
// state 0 one step per cycle and presents the K info bits in parallel.
module rsc_viterbi_decoder #(
    parameter int K    = 40,
    parameter int PM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rsc_viterbi_decoder_if.slave  bus
);
    localparam int              N     = K + 3;
    localparam int              SW    = $clog2(N);
    localparam logic [SW-1:0]   K_S   = SW'(K);
    localparam logic [SW-1:0]   LAST  = SW'(K + 2);
    localparam logic [PM_W-1:0] PRUNE = {1'b1, {(PM_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACS, TB, DONE} state_t;

    state_t          state;
    logic [PM_W-1:0] pm     [8];
    logic [PM_W-1:0] pm_nxt [8];
    logic [7:0]      dec;
    logic [7:0]      surv   [N];
    logic [SW-1:0]   step;
    logic [SW-1:0]   tb_step;
    logic [2:0]      t;
    logic            busy_r;
    logic            done_r;
    logic [0:K-1]    dout_r;
    logic [PM_W-1:0] err_r;
    logic            tail;
    logic            accept;
    logic            tb_d;
    logic [2:0]      tb_p;
    logic            tb_u;

    // A branch leaving predecessor p with feedback bit a. u is recovered from a,
    // which lets tail branches use the same expression as info branches.
    function automatic logic [1:0] branch_metric(input logic [2:0] p, input logic a,
                                                 input logic s, input logic q);
        logic u;
        logic pb;
        u  = a ^ p[1] ^ p[0];
        pb = a ^ p[2] ^ p[0];
        return {1'b0, s ^ u} + {1'b0, q ^ pb};
    endfunction

    assign tail   = (step >= K_S);
    assign accept = bus.in_valid && (state == IDLE || state == ACS);

    // Per-state add-compare-select. Next state n comes from {n[1],n[0],x} with a = n[2].
    for (genvar n = 0; n < 8; n++) begin : g_acs
        localparam logic [2:0] NB = 3'(n);
        localparam logic [2:0] P0 = {NB[1], NB[0], 1'b0};
        localparam logic [2:0] P1 = {NB[1], NB[0], 1'b1};
        logic [PM_W-1:0] c0;
        logic [PM_W-1:0] c1;
        assign c0        = pm[P0] + PM_W'(branch_metric(P0, NB[2], bus.sys_in, bus.par_in));
        assign c1        = pm[P1] + PM_W'(branch_metric(P1, NB[2], bus.sys_in, bus.par_in));
        // A tie keeps the s3=0 predecessor.
        assign dec[n]    = (c1 < c0);
        // Tail steps allow only a=0 branches, so states with n[2]=1 are pruned.
        assign pm_nxt[n] = (tail && NB[2]) ? PRUNE : (dec[n] ? c1 : c0);
    end

    // Traceback: the decision bit selects the predecessor, and the info bit is recovered from it.
    assign tb_d = surv[tb_step][t];
    assign tb_p = {t[1], t[0], tb_d};
    assign tb_u = t[2] ^ tb_p[1] ^ tb_p[0];

    // Survivor memory, one row of decisions per accepted pair.
    always_ff @(posedge clk) begin
        if (!rst && accept)
            surv[step] <= dec;
    end

    // Control FSM, path metrics and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dout_r  <= '0;
            err_r   <= '0;
            step    <= '0;
            tb_step <= '0;
            t       <= '0;
            for (int i = 0; i < 8; i++) pm[i] <= (i == 0) ? '0 : PRUNE;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    pm     <= pm_nxt;
                    step   <= step + 1'b1;
                    busy_r <= 1'b1;
                    state  <= ACS;
                end
                ACS: if (bus.in_valid) begin
                    pm <= pm_nxt;
                    if (step == LAST) begin
                        tb_step <= LAST;
                        t       <= '0;
                        state   <= TB;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                TB: begin
                    if (tb_step < K_S) dout_r[tb_step] <= tb_u;
                    t <= tb_p;
                    if (tb_step == '0) state   <= DONE;
                    else               tb_step <= tb_step - 1'b1;
                end
                DONE: begin
                    done_r <= 1'b1;
                    err_r  <= pm[0];
                    busy_r <= 1'b0;
                    step   <= '0;
                    for (int i = 0; i < 8; i++) pm[i] <= (i == 0) ? '0 : PRUNE;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dout      = dout_r;
    assign bus.err_count = err_r;
endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Directed and randomized bench for rsc_viterbi_decoder. The reference is a
// plain encoder for the RSC code plus the error count that was injected.
// The code's free distance is 6, so up to two channel errors always decode
// back to the sent word, and the ML metric equals the number of flipped bits.
module tb_rsc_viterbi_decoder;
    localparam int K    = 40;
    localparam int PM_W = 8;
    localparam int N    = K + 3;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rsc_viterbi_decoder_if #(.K(K), .PM_W(PM_W)) bus ();

    rsc_viterbi_decoder #(.K(K), .PM_W(PM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: the state is the last three feedback bits, and the tail drives feedback to 0.
    task automatic encode(input logic [0:K-1] w, output logic [0:N-1] s, output logic [0:N-1] p);
        int s1, s2, s3, u, a, pb;
        s1 = 0; s2 = 0; s3 = 0;
        for (int i = 0; i < N; i++) begin
            u    = (i < K) ? int'(w[i]) : (s2 ^ s3);
            a    = u ^ s2 ^ s3;
            pb   = a ^ s1 ^ s3;
            s[i] = u[0];
            p[i] = pb[0];
            s3 = s2; s2 = s1; s1 = a;
        end
    endtask

    task automatic rand_word(output logic [0:K-1] w);
        for (int i = 0; i < K; i++) w[i] = 1'($urandom_range(0, 1));
    endtask

    // Feed one block with optional gaps, then optionally drive junk pairs through TB/DONE.
    task automatic run_block(input string tag, input logic [0:N-1] s, input logic [0:N-1] p,
                             input int gap_max, input bit junk,
                             input logic [0:K-1] exp_w, input int exp_err);
        int  lat;
        bit  seen;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.in_valid = 1'b0;
                bus.sys_in   = 1'($urandom_range(0, 1));
                bus.par_in   = 1'($urandom_range(0, 1));
                tick();
            end
            bus.in_valid = 1'b1;
            bus.sys_in   = s[i];
            bus.par_in   = p[i];
            tick();
            if (i == 0) chk({tag, ".busy_start"}, 64'(bus.busy), 64'(1));
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            bus.in_valid = junk;
            bus.sys_in   = 1'($urandom_range(0, 1));
            bus.par_in   = 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (bus.done) seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(K + 4));
        chk({tag, ".dout"}, 64'(bus.dout), 64'(exp_w));
        chk({tag, ".err_count"}, 64'(bus.err_count), 64'(exp_err));
        chk({tag, ".busy_end"}, 64'(bus.busy), 64'(0));
        tick();
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:K-1] w, z;
        logic [0:N-1] s, p, s2, p2;
        int           ndone, e0, e1;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.sys_in   = 1'b0;
        bus.par_in   = 1'b0;
        repeat (3) tick();
        chk("reset.busy", 64'(bus.busy), 64'(0));
        chk("reset.done", 64'(bus.done), 64'(0));
        chk("reset.dout", 64'(bus.dout), 64'(0));
        chk("reset.err_count", 64'(bus.err_count), 64'(0));
        rst = 1'b0;
        tick();

        // All-zero block, back to back.
        z = '0;
        encode(z, s, p);
        run_block("zero", s, p, 0, 1'b0, z, 0);

        // Clean random word, then single and double injected errors.
        rand_word(w);
        encode(w, s, p);
        run_block("clean", s, p, 0, 1'b0, w, 0);
        p2 = p; p2[17] = ~p2[17];
        run_block("par17", s, p2, 0, 1'b0, w, 1);
        s2 = s; s2[0] = ~s2[0]; s2[39] = ~s2[39];
        run_block("sys0_39", s2, p, 0, 1'b0, w, 2);

        // Random gaps plus junk pairs during TB/DONE.
        run_block("gaps_junk", s, p, 5, 1'b1, w, 0);

        // Two random distinct flips anywhere in the 2*N channel bits.
        rand_word(w);
        encode(w, s, p);
        e0 = $urandom_range(0, 2 * N - 1);
        e1 = (e0 + 1 + $urandom_range(0, 2 * N - 2)) % (2 * N);
        s2 = s; p2 = p;
        if (e0 < N) s2[e0] = ~s2[e0]; else p2[e0 - N] = ~p2[e0 - N];
        if (e1 < N) s2[e1] = ~s2[e1]; else p2[e1 - N] = ~p2[e1 - N];
        run_block("rand2err", s2, p2, 2, 1'b0, w, 2);

        // Abort at pair 20: reset clears everything and no done follows.
        rand_word(w);
        encode(w, s, p);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.sys_in   = s[i];
            bus.par_in   = p[i];
            tick();
        end
        bus.sys_in = s[20];
        bus.par_in = p[20];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort.busy", 64'(bus.busy), 64'(0));
        chk("abort.dout", 64'(bus.dout), 64'(0));
        chk("abort.err_count", 64'(bus.err_count), 64'(0));
        ndone = 0;
        repeat (60) begin
            tick();
            if (bus.done) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'(0));

        // Clean block after abort, then back-to-back blocks.
        run_block("post_abort", s, p, 0, 1'b0, w, 0);
        rand_word(w);
        encode(w, s, p);
        run_block("b2b_0", s, p, 0, 1'b0, w, 0);
        rand_word(w);
        encode(w, s, p);
        run_block("b2b_1", s, p, 0, 1'b0, w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
